// File: rtl/lcd_pkg.sv
// Shared defaults and state encoding for the LCD segment persistence block.
package lcd_pkg;

    localparam int NUM_SEGMENTS_DEF  = 576;
    localparam int DECAY_WIDTH_DEF   = 5;
    localparam int ON_THRESHOLD_DEF  = 16;
    localparam int OFF_THRESHOLD_DEF = 8;
    localparam int RISE_STEP_DEF     = 1;
    localparam int FALL_STEP_DEF     = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/persistence_step.sv
// Saturating counter update plus on/off hysteresis for a single segment.
module persistence_step
    import lcd_pkg::*;
#(
    parameter int DECAY_WIDTH   = DECAY_WIDTH_DEF,
    parameter int ON_THRESHOLD  = ON_THRESHOLD_DEF,
    parameter int OFF_THRESHOLD = OFF_THRESHOLD_DEF,
    parameter int RISE_STEP     = RISE_STEP_DEF,
    parameter int FALL_STEP     = FALL_STEP_DEF
) (
    input  logic [DECAY_WIDTH-1:0] cnt_i,
    input  logic                   up_i,
    input  logic                   bit_i,
    output logic [DECAY_WIDTH-1:0] cnt_o,
    output logic                   bit_o
);

    localparam int W = DECAY_WIDTH + 1;
    localparam logic [W-1:0] MAX_W  = W'((1 << DECAY_WIDTH) - 1);
    localparam logic [W-1:0] RISE_W = W'(RISE_STEP);
    localparam logic [W-1:0] FALL_W = W'(FALL_STEP);
    localparam logic [W-1:0] ON_W   = W'(ON_THRESHOLD);
    localparam logic [W-1:0] OFF_W  = W'(OFF_THRESHOLD);

    logic [W-1:0] wide;
    logic [W-1:0] sum;
    logic [W-1:0] nxt;

    always_comb begin
        wide = {1'b0, cnt_i};
        sum  = wide + RISE_W;
        nxt  = '0;
        if (up_i) begin
            nxt = (sum > MAX_W) ? MAX_W : sum;
        end else if (wide >= FALL_W) begin
            nxt = wide - FALL_W;
        end
        cnt_o = nxt[DECAY_WIDTH-1:0];
        bit_o = bit_i;
        if (nxt >= ON_W) begin
            bit_o = 1'b1;
        end else if (nxt <= OFF_W) begin
            bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/lcd_persistence.sv
// Per-segment persistence emulation: tick-driven sweep over all segments,
// with a vblank-synchronised front buffer for the renderer.
module lcd_persistence
    import lcd_pkg::*;
#(
    parameter int NUM_SEGMENTS  = NUM_SEGMENTS_DEF,
    parameter int DECAY_WIDTH   = DECAY_WIDTH_DEF,
    parameter int ON_THRESHOLD  = ON_THRESHOLD_DEF,
    parameter int OFF_THRESHOLD = OFF_THRESHOLD_DEF,
    parameter int RISE_STEP     = RISE_STEP_DEF,
    parameter int FALL_STEP     = FALL_STEP_DEF,
    localparam int AW           = $clog2(NUM_SEGMENTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SEGMENTS-1:0] raw_segments,
    input  logic                    tick,
    input  logic                    vblank_int,
    input  logic [AW-1:0]           rd_addr,
    output logic                    rd_data,
    output logic                    sweep_busy,
    output logic                    tick_overrun
);

    localparam logic [AW-1:0] LAST = AW'(NUM_SEGMENTS - 1);

    state_e                  state_q, state_d;
    logic                    tick_q, vblank_q, armed_q;
    logic                    pend_q, rd_data_q, ovr_q;
    logic [AW-1:0]           idx_q;
    logic [NUM_SEGMENTS-1:0] snap_q, work_q, front_q, work_d;
    logic [DECAY_WIDTH-1:0]  cnt_q [NUM_SEGMENTS];

    logic                    tick_edge, vb_edge, last;
    logic [DECAY_WIDTH-1:0]  step_cnt;
    logic                    step_bit;

    // armed_q masks edges for the first cycle after reset so that a
    // level held high across reset release is not seen as a new edge.
    assign tick_edge = armed_q & tick & ~tick_q;
    assign vb_edge   = armed_q & vblank_int & ~vblank_q;
    assign last      = (state_q == SWEEP) && (idx_q == LAST);

    persistence_step #(
        .DECAY_WIDTH   (DECAY_WIDTH),
        .ON_THRESHOLD  (ON_THRESHOLD),
        .OFF_THRESHOLD (OFF_THRESHOLD),
        .RISE_STEP     (RISE_STEP),
        .FALL_STEP     (FALL_STEP)
    ) u_step (
        .cnt_i (cnt_q[idx_q]),
        .up_i  (snap_q[idx_q]),
        .bit_i (work_q[idx_q]),
        .cnt_o (step_cnt),
        .bit_o (step_bit)
    );

    always_comb begin
        work_d = work_q;
        if (state_q == SWEEP) begin
            work_d[idx_q] = step_bit;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (tick_edge) state_d = SWEEP;
            SWEEP: if (last)      state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            vblank_q  <= 1'b0;
            armed_q   <= 1'b0;
            pend_q    <= 1'b0;
            rd_data_q <= 1'b0;
            ovr_q     <= 1'b0;
            idx_q     <= '0;
            snap_q    <= '0;
            work_q    <= '0;
            front_q   <= '0;
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            tick_q   <= tick;
            vblank_q <= vblank_int;
            armed_q  <= 1'b1;
            ovr_q    <= tick_edge && (state_q == SWEEP);
            if (state_q == IDLE) begin
                if (tick_edge) begin
                    snap_q <= raw_segments;
                    idx_q  <= '0;
                end
                if (vb_edge) begin
                    front_q <= work_q;
                end
            end else begin
                cnt_q[idx_q] <= step_cnt;
                work_q       <= work_d;
                idx_q        <= idx_q + AW'(1);
                // A deferred request only lands if vblank is still active.
                if (last) begin
                    pend_q <= 1'b0;
                    if ((pend_q || vb_edge) && vblank_int) begin
                        front_q <= work_d;
                    end
                end else if (vb_edge) begin
                    pend_q <= 1'b1;
                end
            end
            if (int'(rd_addr) < NUM_SEGMENTS) begin
                rd_data_q <= front_q[rd_addr];
            end else begin
                rd_data_q <= 1'b0;
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign sweep_busy   = (state_q == SWEEP);
    assign tick_overrun = ovr_q;

endmodule

// File: doc/lcd_persistence.md
LCD_PERSISTENCE -- requirements
Module: lcd_persistence

Interface
REQ-001 Parameter NUM_SEGMENTS, default 576 (9x16x4), total segment count.
REQ-002 Parameter DECAY_WIDTH, default 5, bit width of each per-segment persistence counter.
REQ-003 Parameter ON_THRESHOLD, default 16; counter value at or above which a segment is shown.
REQ-004 Parameter OFF_THRESHOLD, default 8, must be less than ON_THRESHOLD; counter value at or below which a segment is hidden.
REQ-005 Parameters RISE_STEP and FALL_STEP, default 1 each, counter increment and decrement per tick.
REQ-006 clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 raw_segments  in  NUM_SEGMENTS  instantaneous segment drive from normaliser, bit i = segment i.
REQ-009 tick  in  1  persistence time base (1 kHz divider level); rising edge starts a sweep.
REQ-010 vblank_int  in  1  video vertical blank; rising edge requests front-buffer update.
REQ-011 rd_addr  in  clog2(NUM_SEGMENTS)  front-buffer read address from renderer.
REQ-012 rd_data  out  1  front-buffer bit at rd_addr, registered, one-cycle latency.
REQ-013 sweep_busy  out  1  high while a sweep is in progress.
REQ-014 tick_overrun  out  1  one-cycle pulse when a tick edge is dropped.

Function
REQ-015 Edge detection SHALL use registered previous values of tick and vblank_int; an edge is current=1 and previous=0.
REQ-016 FSM states SHALL be IDLE and SWEEP; reset enters IDLE.
REQ-017 On tick edge in IDLE at clock edge k: capture raw_segments into snapshot register, index=0, enter SWEEP; sweep_busy high from after edge k.
REQ-018 In SWEEP, segment i SHALL be updated at edge k+1+i, one segment per cycle, using the snapshot bit, not live raw_segments.
REQ-019 Update: snapshot bit 1 -> counter = min(counter+RISE_STEP, 2^DECAY_WIDTH-1); bit 0 -> counter = max(counter-FALL_STEP, 0); arithmetic one bit wider than DECAY_WIDTH, no wrap.
REQ-020 Working display bit SHALL be set when the new counter is >= ON_THRESHOLD, cleared when the new counter is <= OFF_THRESHOLD, held otherwise (hysteresis).
REQ-021 After updating index NUM_SEGMENTS-1 (edge k+NUM_SEGMENTS), FSM SHALL return to IDLE and sweep_busy SHALL fall after that edge.
REQ-022 Tick edge while in SWEEP SHALL be ignored and tick_overrun pulsed for exactly one cycle; the sweep in progress is unaffected.
REQ-023 On vblank edge in IDLE, the whole working display vector SHALL be copied to the front buffer at that edge.
REQ-024 On vblank edge in SWEEP, a pending flag SHALL be set; at sweep completion, copy occurs on the completing edge if vblank_int is still high, else the request is discarded and the front buffer holds.
REQ-025 Simultaneous tick and vblank edges in IDLE: copy uses working bits before the new sweep; sweep starts the same edge.
REQ-026 Front buffer SHALL only change as in REQ-023/024, never mid-frame.
REQ-027 rd_data SHALL reflect front buffer at rd_addr as of the previous edge; rd_addr >= NUM_SEGMENTS returns 0.

Reset
REQ-028 Reset SHALL clear all counters, working bits, front buffer, snapshot, index, pending flag and edge registers, and enter IDLE.
REQ-029 After reset, rd_data, sweep_busy and tick_overrun SHALL be 0; reset mid-sweep aborts with no further updates.
REQ-030 Tick or vblank held high through reset release SHALL NOT produce an edge.

Structure
REQ-031 Shared package lcd_pkg SHALL hold defaults for segment count, DECAY_WIDTH, thresholds and the FSM state enum.
REQ-032 One sub-module, persistence_step, SHALL implement the combinational saturating update and hysteresis for a single segment.

Verification (NUM_SEGMENTS=8, DECAY_WIDTH=3, ON=5, OFF=2, steps 1)
REQ-033 raw=8'hFF, 5 ticks -> bits 0 after tick 4, front buffer 8'hFF after next vblank following tick 5; 10 ticks -> counters saturate at 7.
REQ-034 From saturation, raw=8'h00 -> bits stay 1 through tick 4 (counter 3), clear on tick 5 (counter 2); counters floor at 0.
REQ-035 Counter at 4 after rise, raw alternates 0/1 per tick -> display bit holds at the value it had entering the band (no flicker).
REQ-036 Tick edge 3 cycles after a previous tick -> tick_overrun one pulse, sweep_busy high exactly 8 cycles from first tick.
REQ-037 Vblank edge mid-sweep with vblank held 10 cycles -> front buffer updates on sweep completion edge; vblank held 2 cycles -> no update.
REQ-038 Reset asserted at sweep index 4 -> all outputs 0, IDLE next cycle, rd_data 0 for all addresses.
